lfsr_checker: RTL and testbench
===============================

// Module: lfsr_checker
// PURPOSE
//  Receive-side checker for the 16-bit Fibonacci LFSR generator. Samples the
//  generator's parallel state word each valid cycle and self-synchronises to
//  the sequence. Once locked, predicts every following word and counts
//  mismatches. Used as the sink in LFSR link and bench tests.
// PARAMETERS
//  WIDTH        16       LFSR width; in_state width
//  TAPS         16'hB400 feedback mask (x^16+x^14+x^13+x^11+1); fb = ^(s & TAPS)
//  LOCK_COUNT   4        consecutive matches needed in VERIFY to declare lock
//  UNLOCK_COUNT 3        consecutive mismatches in LOCKED that drop lock
//  CNT_W        16       err_count width
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high; priority over all inputs
//  in_valid   in   1      in_state holds a valid word this cycle
//  in_state   in   WIDTH  generator state word
//  locked     out  1      checker is in LOCKED
//  err_pulse  out  1      one-cycle pulse: mismatch while LOCKED
//  zero_seen  out  1      one-cycle pulse: all-zero word sampled (illegal state)
//  err_count  out  CNT_W  saturating mismatch count while LOCKED
// BEHAVIOUR
//  - next(s) = {s[WIDTH-2:0], ^(s & TAPS)}; must match the generator exactly.
//  - Reset: FSM=HUNT; locked=0, err_pulse=0, zero_seen=0, err_count=0;
//    exp=0, match_cnt=0, miss_cnt=0. All outputs are registered.
//  - in_valid=0: all state held; err_pulse and zero_seen are 0.
//  - HUNT, on a valid word:
//    - word==0: zero_seen=1 next cycle; stay in HUNT.
//    - otherwise: exp<=next(word), match_cnt<=0, go to VERIFY.
//  - VERIFY, on a valid word:
//    - word==exp: match_cnt++, exp<=next(word). When match_cnt reaches
//      LOCK_COUNT, go to LOCKED.
//    - mismatch: exp<=next(word), match_cnt<=0, stay in VERIFY. Not counted.
//  - LOCKED: exp always advances, exp<=next(exp), and is never reseeded, so
//    one corrupt word costs exactly one error. On a valid word:
//    - match: miss_cnt<=0.
//    - mismatch: err_pulse=1 next cycle; err_count++ (saturates at all-ones);
//      miss_cnt++. When miss_cnt reaches UNLOCK_COUNT: FSM=HUNT, locked=0,
//      miss_cnt<=0. The offending word is not used as a seed.
//  - Latency:
//    - locked rises the cycle after the (LOCK_COUNT+1)th clean valid word
//      (1 seed + LOCK_COUNT matches).
//    - err_pulse rises the cycle after the bad word is sampled.
//  - A zero word sampled while LOCKED is an ordinary mismatch and also pulses
//    zero_seen. A zero word in VERIFY is a mismatch and pulses zero_seen;
//    the FSM returns to HUNT.
//  - err_count clears only on reset and persists across lock loss.
//  - Reset mid-operation: all state is cleared at the next edge regardless of
//    in_valid.
// STRUCTURE
//  - Shared package lfsr_pkg: WIDTH, TAPS, function lfsr_next(), and the FSM
//    state enum (HUNT/VERIFY/LOCKED). The generator uses the same package.
//  - One sub-module: lfsr_next_state, the combinational step wrapping
//    lfsr_next(). It is instanced twice: on in_state (seeding) and on exp
//    (prediction).
//  - Everything else is a single FSM plus counters in this module.
// TESTING
//  1. Reset, then words 000D,001A,0034,0068,00D0 with in_valid=1
//     -> locked=1 the cycle after 00D0; err_count=0.
//  2. While locked, replace one word with FFFF, then resume the correct
//     sequence -> one err_pulse; err_count=1; locked stays 1.
//  3. While locked, corrupt 3 consecutive words -> err_count +3; locked=0 the
//     cycle after the 3rd. A clean stream then relocks after 5 valid words.
//  4. While locked, drop in_valid for 10 cycles, then resume the correct next
//     word -> no err_pulse; locked held throughout.
//  5. In HUNT, drive 0000 -> zero_seen pulse; stays unlocked. Next word 000D
//     seeds normally.
//  6. CNT_W=4, locked, alternate 20 bad and good words -> err_count=4'hF held
//     at saturation; locked=1. Assert reset -> locked=0, err_count=0 next cycle.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 16-bit Fibonacci LFSR generator and checker.
package lfsr_pkg;

  localparam int unsigned WIDTH = 16;
  localparam logic [WIDTH-1:0] TAPS = 16'hB400;

  typedef enum logic [1:0] {
    StHunt,
    StVerify,
    StLocked
  } lfsr_state_e;

  // Shift left, feedback into bit 0; generator and checker must agree bit for bit.
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_next_state.sv
// Combinational single-step of the shared LFSR.
module lfsr_next_state
  import lfsr_pkg::*;
(
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] next_o
);

  assign next_o = lfsr_next(state_i);

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: self-synchronises to the incoming state words,
// then predicts each word and counts mismatches while locked.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned UNLOCK_COUNT = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_state,
  output logic             locked,
  output logic             err_pulse,
  output logic             zero_seen,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned MatchW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MissW  = $clog2(UNLOCK_COUNT + 1);

  lfsr_state_e      state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] in_next, exp_next;
  logic [MatchW-1:0] match_cnt_q, match_cnt_d;
  logic [MissW-1:0]  miss_cnt_q, miss_cnt_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             zero_seen_q, zero_seen_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             is_zero, is_match;

  lfsr_next_state u_seed_next (
    .state_i (in_state),
    .next_o  (in_next)
  );

  lfsr_next_state u_pred_next (
    .state_i (exp_q),
    .next_o  (exp_next)
  );

  assign is_zero  = (in_state == '0);
  assign is_match = (in_state == exp_q);

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_pulse_d = 1'b0;
    zero_seen_d = 1'b0;
    err_count_d = err_count_q;

    if (in_valid) begin
      zero_seen_d = is_zero;
      unique case (state_q)
        StHunt: begin
          if (!is_zero) begin
            exp_d       = in_next;
            match_cnt_d = '0;
            state_d     = StVerify;
          end
        end
        StVerify: begin
          if (is_zero) begin
            match_cnt_d = '0;
            state_d     = StHunt;
          end else if (is_match) begin
            exp_d = in_next;
            if (match_cnt_q == MatchW'(LOCK_COUNT - 1)) begin
              match_cnt_d = '0;
              miss_cnt_d  = '0;
              state_d     = StLocked;
            end else begin
              match_cnt_d = match_cnt_q + 1'b1;
            end
          end else begin
            exp_d       = in_next;
            match_cnt_d = '0;
          end
        end
        StLocked: begin
          // Prediction free-runs once locked so a corrupt word never reseeds it.
          exp_d = exp_next;
          if (is_match) begin
            miss_cnt_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
            if (miss_cnt_q == MissW'(UNLOCK_COUNT - 1)) begin
              miss_cnt_d = '0;
              state_d    = StHunt;
            end else begin
              miss_cnt_d = miss_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end

    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StHunt;
      exp_q       <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      zero_seen_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      zero_seen_q <= zero_seen_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign zero_seen = zero_seen_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: directed words with hand-derived expected outputs.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_state = '0;
  logic        locked, err_pulse, zero_seen;
  logic [3:0]  err_count;

  typedef struct {
    logic       locked;
    logic       err;
    logic       zero;
    logic [3:0] cnt;
    string      name;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] g;
  logic [15:0] bw;
  logic [3:0]  ec;

  always #5 clk = ~clk;

  lfsr_checker #(
    .LOCK_COUNT   (4),
    .UNLOCK_COUNT (3),
    .CNT_W        (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_state  (in_state),
    .locked    (locked),
    .err_pulse (err_pulse),
    .zero_seen (zero_seen),
    .err_count (err_count)
  );

  // Independent model of x^16+x^14+x^13+x^11+1 stepping.
  function automatic logic [15:0] nx(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic drive(input logic r, input logic v, input logic [15:0] w, input logic el,
                       input logic ee, input logic ez, input logic [3:0] cnt, input string nm);
    exp_t e;
    @(negedge clk);
    reset    = r;
    in_valid = v;
    in_state = w;
    e.locked = el;
    e.err    = ee;
    e.zero   = ez;
    e.cnt    = cnt;
    e.name   = nm;
    sb_q.push_back(e);
  endtask

  task automatic good_word(input logic el, input logic [3:0] cnt, input string nm);
    drive(1'b0, 1'b1, g, el, 1'b0, 1'b0, cnt, nm);
    g = nx(g);
  endtask

  task automatic bad_word(input logic el, input logic [3:0] cnt, input string nm);
    drive(1'b0, 1'b1, ~g, el, 1'b1, 1'b0, cnt, nm);
    g = nx(g);
  endtask

  task automatic idle(input logic el, input logic [3:0] cnt);
    drive(1'b0, 1'b0, 16'h0000, el, 1'b0, 1'b0, cnt, "idle");
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_cmp++;
      if ({locked, err_pulse, zero_seen, err_count} !==
          {mon_e.locked, mon_e.err, mon_e.zero, mon_e.cnt}) begin
        n_bad++;
        $display("FAIL %s @%0t: got locked=%b err=%b zero=%b cnt=%h, want locked=%b err=%b zero=%b cnt=%h",
                 mon_e.name, $time, locked, err_pulse, zero_seen, err_count,
                 mon_e.locked, mon_e.err, mon_e.zero, mon_e.cnt);
      end
    end
  end

  initial begin
    drive(1'b1, 1'b0, 16'h0000, 0, 0, 0, 4'h0, "reset");

    // Acquire lock from 000D.
    drive(1'b0, 1'b1, 16'h000D, 0, 0, 0, 4'h0, "seed");
    drive(1'b0, 1'b1, 16'h001A, 0, 0, 0, 4'h0, "match1");
    drive(1'b0, 1'b1, 16'h0034, 0, 0, 0, 4'h0, "match2");
    drive(1'b0, 1'b1, 16'h0068, 0, 0, 0, 4'h0, "match3");
    drive(1'b0, 1'b1, 16'h00D0, 1, 0, 0, 4'h0, "lock");
    g = 16'h01A0;

    // Single corrupt word.
    good_word(1, 4'h0, "locked_good");
    drive(1'b0, 1'b1, 16'hFFFF, 1, 1, 0, 4'h1, "single_bad");
    g = nx(g);
    good_word(1, 4'h1, "resume1");
    good_word(1, 4'h1, "resume2");

    // Three consecutive errors drop lock; clean stream relocks after 5 words.
    bad_word(1, 4'h2, "burst1");
    bad_word(1, 4'h3, "burst2");
    bad_word(0, 4'h4, "burst3_unlock");
    good_word(0, 4'h4, "reseed");
    good_word(0, 4'h4, "rematch1");
    good_word(0, 4'h4, "rematch2");
    good_word(0, 4'h4, "rematch3");
    good_word(1, 4'h4, "relock");

    // Gap in in_valid while locked.
    for (int i = 0; i < 10; i++) idle(1, 4'h4);
    good_word(1, 4'h4, "after_gap");

    // Back to HUNT, then zero words in HUNT and VERIFY.
    bad_word(1, 4'h5, "drop1");
    bad_word(1, 4'h6, "drop2");
    bad_word(0, 4'h7, "drop3");
    drive(1'b0, 1'b1, 16'h0000, 0, 0, 1, 4'h7, "zero_hunt");
    drive(1'b0, 1'b1, 16'h000D, 0, 0, 0, 4'h7, "seed_after_zero");
    drive(1'b0, 1'b1, 16'h0000, 0, 0, 1, 4'h7, "zero_verify");
    drive(1'b0, 1'b1, 16'h000D, 0, 0, 0, 4'h7, "reseed2");
    drive(1'b0, 1'b1, 16'h001A, 0, 0, 0, 4'h7, "m1b");
    drive(1'b0, 1'b1, 16'h0034, 0, 0, 0, 4'h7, "m2b");
    drive(1'b0, 1'b1, 16'h0068, 0, 0, 0, 4'h7, "m3b");
    drive(1'b0, 1'b1, 16'h00D0, 1, 0, 0, 4'h7, "lock2");
    g = 16'h01A0;

    // Alternate bad/good: count saturates at F, lock held. First bad is a zero word.
    for (int i = 0; i < 20; i++) begin
      bw = (i == 0) ? 16'h0000 : ~g;
      ec = (8 + i > 15) ? 4'hF : 4'(8 + i);
      drive(1'b0, 1'b1, bw, 1, 1, (i == 0), ec, "sat_bad");
      g = nx(g);
      good_word(1, ec, "sat_good");
    end

    // Reset with valid, non-matching input present.
    drive(1'b1, 1'b1, 16'hFFFF, 0, 0, 0, 4'h0, "reset_mid");
    drive(1'b0, 1'b1, 16'h000D, 0, 0, 0, 4'h0, "post_reset_seed");
    idle(0, 4'h0);

    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
